// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_responder
//  Purpose  : Memory-side responder for the MERA-400 system bus. Accepts
//             read/write requests (NB segment, AD address, DT data, QB user
//             flag) and answers OK (done) or EN (refused) with the bus
//             four-phase handshake. Unmapped or malformed requests are left
//             unanswered so the requester's own timeout fires. Holds 16
//             segments of 2^ADDR_BITS 16-bit words plus a per-segment
//             user-mode write-protect map.
//  Ports    : clk_sys  in   system clock
//             rst_     in   asynchronous reset, active low
//             r_       in   read request, active low, asynchronous
//             w_       in   write request, active low, asynchronous
//             nb_      in   [0:3]  segment number, active low
//             ad_      in   [0:15] word address, active low
//             qb_      in   user-mode flag, active low
//             dt_i_    in   [0:15] write data, active low
//             dt_o_    out  [0:15] read data, active low, all ones when idle
//             ok_      out  access done, active low
//             en_      out  access refused, active low
//             busy     out  high whenever the FSM is not idle
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_responder #(
  parameter int unsigned ADDR_BITS   = 6,
  parameter logic [15:0] NB_MAP      = 16'hFFFF,
  parameter logic [15:0] WP_MASK     = 16'h8000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_sys,
  input  logic        rst_,
  input  logic        r_,
  input  logic        w_,
  input  logic [0:3]  nb_,
  input  logic [0:15] ad_,
  input  logic        qb_,
  input  logic [0:15] dt_i_,
  output logic [0:15] dt_o_,
  output logic        ok_,
  output logic        en_,
  output logic        busy
);

  localparam int unsigned MEM_AW    = 4 + ADDR_BITS;
  localparam int unsigned MEM_WORDS = 1 << MEM_AW;
  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ANSWER = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Request synchronisers (reset to the released level)
  // --------------------------------------------------------------------------
  logic r_s1_q, r_s1_d, r_s2_q, r_s2_d;
  logic w_s1_q, w_s1_d, w_s2_q, w_s2_d;

  always_comb begin
    r_s1_d = r_;
    r_s2_d = r_s1_q;
    w_s1_d = w_;
    w_s2_d = w_s1_q;
  end

  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      r_s1_q <= 1'b1;
      r_s2_q <= 1'b1;
      w_s1_q <= 1'b1;
      w_s2_q <= 1'b1;
    end else begin
      r_s1_q <= r_s1_d;
      r_s2_q <= r_s2_d;
      w_s1_q <= w_s1_d;
      w_s2_q <= w_s2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bus field decode (true polarity). These fields are only looked at on the
  // capture edge; the bus holds them stable while the request is asserted.
  // --------------------------------------------------------------------------
  logic [3:0]  nb_in;
  logic [15:0] ad_in;
  logic        user_mode;
  logic        seg_mapped;
  logic        seg_wp;
  logic        addr_in_range;

  assign nb_in     = ~nb_;
  assign ad_in     = ~ad_;
  assign user_mode = ~qb_;

  // Maps are numbered with segment 0 in the most significant bit.
  assign seg_mapped = NB_MAP[4'd15 - nb_in];
  assign seg_wp     = WP_MASK[4'd15 - nb_in];

  generate
    if (ADDR_BITS < 16) begin : g_addr_part
      assign addr_in_range = (ad_in[15:ADDR_BITS] == '0);
    end else begin : g_addr_full
      assign addr_in_range = 1'b1;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Captured request and answer registers
  // --------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             nb_q, nb_d;
  logic [ADDR_BITS-1:0]   ad_q, ad_d;
  logic                   wr_q, wr_d;
  logic [15:0]            dt_q, dt_d;
  logic                   ok_q, ok_d;
  logic                   en_q, en_d;
  logic [15:0]            dt_o_q, dt_o_d;

  // --------------------------------------------------------------------------
  // Word storage. Deliberately not reset: contents survive a reset like core.
  // --------------------------------------------------------------------------
  logic [15:0]       mem [MEM_WORDS];
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_rdata;

  assign mem_addr  = {nb_q, ad_q};
  assign mem_rdata = mem[mem_addr];

  always_ff @(posedge clk_sys) begin
    if (mem_we) begin
      mem[mem_addr] <= dt_q;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  logic req_any;
  logic req_both;
  logic req_released;

  always_comb begin
    req_any      = !r_s2_q || !w_s2_q;
    req_both     = !r_s2_q && !w_s2_q;
    req_released = r_s2_q && w_s2_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nb_d    = nb_q;
    ad_d    = ad_q;
    wr_d    = wr_q;
    dt_d    = dt_q;
    ok_d    = ok_q;
    en_d    = en_q;
    dt_o_d  = dt_o_q;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          nb_d = nb_in;
          ad_d = ad_in[ADDR_BITS-1:0];
          wr_d = !w_s2_q;
          dt_d = ~dt_i_;
          if (req_both || !seg_mapped || !addr_in_range) begin
            // Stay silent; the requester's timeout reports the fault.
            state_d = ST_IGNORE;
          end else if (!w_s2_q && user_mode && seg_wp) begin
            en_d    = 1'b0;
            state_d = ST_ANSWER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        // cnt_q == 1 is the edge on which the counter reaches zero. The
        // access completes even if the request has already been dropped.
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            dt_o_d = ~mem_rdata;
          end
          ok_d    = 1'b0;
          state_d = ST_ANSWER;
        end
      end

      ST_ANSWER: begin
        if (req_released) begin
          ok_d    = 1'b1;
          en_d    = 1'b1;
          dt_o_d  = 16'hFFFF;
          state_d = ST_IDLE;
        end
      end

      ST_IGNORE: begin
        if (req_released) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nb_q    <= '0;
      ad_q    <= '0;
      wr_q    <= 1'b0;
      dt_q    <= '0;
      ok_q    <= 1'b1;
      en_q    <= 1'b1;
      dt_o_q  <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      ad_q    <= ad_d;
      wr_q    <= wr_d;
      dt_q    <= dt_d;
      ok_q    <= ok_d;
      en_q    <= en_d;
      dt_o_q  <= dt_o_d;
    end
  end

  assign ok_   = ok_q;
  assign en_   = en_q;
  assign dt_o_ = dt_o_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_responder
//  Purpose  : Self-checking bench for mem_bus_responder. One instance with
//             all segments mapped, one with segment 0 unmapped.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_responder;

  localparam int WAIT     = 2;
  localparam int K_OK     = 0;
  localparam int K_EN     = 1;
  localparam int K_SIL    = 2;
  localparam logic [15:0] MAP_MAIN = 16'hFFFF;
  localparam logic [15:0] MAP_UM   = 16'h7FFF;
  localparam logic [15:0] WP       = 16'h8000;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst_, r_, w_, qb_;
  logic [0:3]  nb_;
  logic [0:15] ad_, dt_i_;
  logic [0:15] dt_o_, dt_o_um_;
  logic        ok_, en_, busy, ok_um_, en_um_, busy_um;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          kind;
    logic [15:0] data;   // expected dt_o_ while answering
    int          lat;    // sampled cycles from drive until answer
    bit          um;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model[int];

  mem_bus_responder #(.ADDR_BITS(6), .NB_MAP(16'hFFFF), .WP_MASK(16'h8000), .WAIT_CYCLES(2)) dut (
    .clk_sys(clk_sys), .rst_(rst_), .r_(r_), .w_(w_), .nb_(nb_), .ad_(ad_), .qb_(qb_),
    .dt_i_(dt_i_), .dt_o_(dt_o_), .ok_(ok_), .en_(en_), .busy(busy)
  );

  mem_bus_responder #(.ADDR_BITS(6), .NB_MAP(16'h7FFF), .WP_MASK(16'h8000), .WAIT_CYCLES(2)) dut_um (
    .clk_sys(clk_sys), .rst_(rst_), .r_(r_), .w_(w_), .nb_(nb_), .ad_(ad_), .qb_(qb_),
    .dt_i_(dt_i_), .dt_o_(dt_o_um_), .ok_(ok_um_), .en_(en_um_), .busy(busy_um)
  );

  // Drive a request and push what the bench expects to see for it.
  task automatic drive_req(input bit rd, input bit wr, input logic [3:0] nb,
                           input logic [15:0] ad, input bit qb, input logic [15:0] data,
                           input bit um);
    exp_t        e;
    int          key;
    logic [15:0] map_sel;
    logic [15:0] wp_sel;
    @(negedge clk_sys);
    map_sel = um ? MAP_UM : MAP_MAIN;
    wp_sel  = WP;
    key     = int'(nb) * 64 + int'(ad[5:0]);
    e.um    = um;
    e.data  = 16'hFFFF;
    if ((rd && wr) || !map_sel[15 - nb] || (ad[15:6] != 10'd0)) begin
      e.kind = K_SIL; e.lat = 0;
    end else if (wr && qb && wp_sel[15 - nb]) begin
      e.kind = K_EN; e.lat = 3;
    end else begin
      e.kind = K_OK; e.lat = 3 + WAIT;
      if (wr) model[key] = data;
      else    e.data = ~model[key];
    end
    sb.push_back(e);
    nb_ = ~nb; ad_ = ~ad; qb_ = ~qb; dt_i_ = ~data;
    r_ = ~rd;  w_ = ~wr;
  endtask

  task automatic check_answer(input string name);
    exp_t       e;
    int         n;
    bit         seen_idle, got;
    logic [1:0] exp_oe;
    e = sb.pop_front();
    n = 0; seen_idle = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk_sys);
      n++;
      if (ok_ === 1'b1 && en_ === 1'b1) seen_idle = 1;
      else if (seen_idle) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s answer: none within %0d cycles, required one after %0d", name, n, e.lat);
    end else begin
      exp_oe = (e.kind == K_EN) ? 2'b10 : 2'b01;
      checks++;
      if ({ok_, en_} !== exp_oe) begin
        failures++;
        $display("FAIL %s ok_/en_: got %b required %b", name, {ok_, en_}, exp_oe);
      end
      checks++;
      if (n != e.lat) begin
        failures++;
        $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
      end
      checks++;
      if (dt_o_ !== e.data) begin
        failures++;
        $display("FAIL %s dt_o_: got %h required %h", name, dt_o_, e.data);
      end
    end
  endtask

  task automatic release_and_check(input string name, input bit um);
    int n;
    bit done;
    @(negedge clk_sys);
    r_ = 1'b1; w_ = 1'b1;
    n = 0; done = 0;
    while (!done && n < 20) begin
      @(negedge clk_sys);
      n++;
      if (um) done = (ok_um_ === 1'b1) && (en_um_ === 1'b1) && (busy_um === 1'b0) && (dt_o_um_ === 16'hFFFF);
      else    done = (ok_ === 1'b1) && (en_ === 1'b1) && (busy === 1'b0) && (dt_o_ === 16'hFFFF);
    end
    checks++;
    if (!done || n != 3) begin
      failures++;
      $display("FAIL %s release: idle after %0d cycles (reached=%0d) required 3", name, n, done);
    end
  endtask

  task automatic check_silent(input string name, input int cycles);
    exp_t e;
    bit   quiet;
    int   bad_at;
    e = sb.pop_front();
    quiet = 1; bad_at = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk_sys);
      if (e.um) begin
        if (ok_um_ !== 1'b1 || en_um_ !== 1'b1 || (i >= 3 && busy_um !== 1'b1)) begin
          if (quiet) bad_at = i;
          quiet = 0;
        end
      end else begin
        if (ok_ !== 1'b1 || en_ !== 1'b1 || (i >= 3 && busy !== 1'b1)) begin
          if (quiet) bad_at = i;
          quiet = 0;
        end
      end
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL %s silence: answer or idle at cycle %0d, required silent and busy", name, bad_at);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({ok_, en_, busy, dt_o_} !== {1'b1, 1'b1, 1'b0, 16'hFFFF}) begin
      failures++;
      $display("FAIL reset_defaults: got ok=%b en=%b busy=%b dt=%h required 1 1 0 ffff", ok_, en_, busy, dt_o_);
    end
    rst_ = 1'b1;
    drive_req(0, 1, 4'd1, 16'd2, 0, 16'hA5A5, 0);
    check_answer("reset_prewrite");
    release_and_check("reset_prewrite", 0);
    // Raw read of nb=1, reset in the middle of ACCESS.
    @(negedge clk_sys);
    nb_ = ~4'd1; ad_ = ~16'd2; qb_ = 1'b1; r_ = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_access_busy: got %b required 1", busy);
    end
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if ({ok_, en_, busy, dt_o_} !== {1'b1, 1'b1, 1'b0, 16'hFFFF}) begin
      failures++;
      $display("FAIL reset_mid_access: got ok=%b en=%b busy=%b dt=%h required 1 1 0 ffff", ok_, en_, busy, dt_o_);
    end
    r_ = 1'b1;
    repeat (2) @(negedge clk_sys);
    rst_ = 1'b1;
    // Reset while an OK answer with data is being held.
    drive_req(1, 0, 4'd1, 16'd2, 0, 16'h0, 0);
    check_answer("reset_answer_read");
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if ({ok_, en_, busy, dt_o_} !== {1'b1, 1'b1, 1'b0, 16'hFFFF}) begin
      failures++;
      $display("FAIL reset_mid_answer: got ok=%b en=%b busy=%b dt=%h required 1 1 0 ffff", ok_, en_, busy, dt_o_);
    end
    r_ = 1'b1;
    repeat (2) @(negedge clk_sys);
    rst_ = 1'b1;
    drive_req(1, 0, 4'd1, 16'd2, 0, 16'h0, 0);
    check_answer("reset_storage_kept");
    release_and_check("reset_storage_kept", 0);
  endtask

  task automatic test_write_read;
    drive_req(0, 1, 4'd3, 16'd5, 0, 16'h1234, 0);
    check_answer("wr_3_5");
    release_and_check("wr_3_5", 0);
    drive_req(1, 0, 4'd3, 16'd5, 0, 16'h0, 0);
    check_answer("rd_3_5");
    release_and_check("rd_3_5", 0);
    drive_req(0, 1, 4'd15, 16'd63, 0, 16'hC3A1, 0);
    check_answer("wr_15_63");
    release_and_check("wr_15_63", 0);
    drive_req(1, 0, 4'd15, 16'd63, 1, 16'h0, 0);
    check_answer("rd_15_63_user");
    release_and_check("rd_15_63_user", 0);
  endtask

  task automatic test_write_protect;
    drive_req(0, 1, 4'd0, 16'd1, 0, 16'h0F0F, 0);
    check_answer("wp_sup_write");
    release_and_check("wp_sup_write", 0);
    drive_req(0, 1, 4'd0, 16'd1, 1, 16'hF0F0, 0);
    check_answer("wp_user_refused");
    release_and_check("wp_user_refused", 0);
    drive_req(1, 0, 4'd0, 16'd1, 1, 16'h0, 0);
    check_answer("wp_read_prior");
    release_and_check("wp_read_prior", 0);
    drive_req(0, 1, 4'd0, 16'd1, 0, 16'hF0F0, 0);
    check_answer("wp_sup_rewrite");
    release_and_check("wp_sup_rewrite", 0);
    drive_req(1, 0, 4'd0, 16'd1, 0, 16'h0, 0);
    check_answer("wp_read_new");
    release_and_check("wp_read_new", 0);
  endtask

  task automatic test_unmapped;
    drive_req(1, 0, 4'd0, 16'd3, 0, 16'h0, 1);
    check_silent("unmapped_nb0", 100);
    release_and_check("unmapped_nb0", 1);
  endtask

  task automatic test_addr_range;
    drive_req(1, 0, 4'd3, 16'h0040, 0, 16'h0, 0);
    check_silent("addr_0040", 20);
    release_and_check("addr_0040", 0);
  endtask

  task automatic test_protocol_error;
    drive_req(1, 1, 4'd3, 16'd5, 0, 16'h7777, 0);
    check_silent("r_and_w", 20);
    release_and_check("r_and_w", 0);
    drive_req(1, 0, 4'd3, 16'd5, 0, 16'h0, 0);
    check_answer("after_proto_err");
    release_and_check("after_proto_err", 0);
  endtask

  task automatic test_back_to_back;
    drive_req(0, 1, 4'd5, 16'd10, 0, 16'hBEEF, 0);
    check_answer("b2b_setup");
    release_and_check("b2b_setup", 0);
    drive_req(1, 0, 4'd5, 16'd10, 0, 16'h0, 0);
    check_answer("b2b_first");
    @(negedge clk_sys);
    r_ = 1'b1;  // released for a single clock before the next request
    drive_req(1, 0, 4'd5, 16'd10, 0, 16'h0, 0);
    check_answer("b2b_second");
    release_and_check("b2b_second", 0);
  endtask

  task automatic test_drop;
    exp_t e;
    int   lows, first;
    bit   data_ok;
    drive_req(0, 1, 4'd7, 16'd9, 0, 16'h5A5A, 0);
    repeat (3) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_busy: got %b required 1", busy);
    end
    w_ = 1'b1;
    e = sb.pop_front();
    lows = 0; first = 0; data_ok = 1;
    for (int i = 4; i <= 12; i++) begin
      @(negedge clk_sys);
      if (ok_ !== 1'b1) begin
        lows++;
        if (first == 0) first = i;
        if (dt_o_ !== e.data || en_ !== 1'b1) data_ok = 0;
      end
    end
    checks++;
    if (lows != 1 || first != e.lat) begin
      failures++;
      $display("FAIL drop_pulse: got %0d low cycles starting %0d required 1 starting %0d", lows, first, e.lat);
    end
    checks++;
    if (!data_ok || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_end: got data_ok=%0d busy=%b required 1 0", data_ok, busy);
    end
    drive_req(1, 0, 4'd7, 16'd9, 0, 16'h0, 0);
    check_answer("drop_readback");
    release_and_check("drop_readback", 0);
  endtask

  initial begin
    rst_ = 1'b0; r_ = 1'b1; w_ = 1'b1; qb_ = 1'b1;
    nb_ = '1; ad_ = '1; dt_i_ = '1;
    test_reset;
    test_write_read;
    test_write_protect;
    test_unmapped;
    test_addr_range;
    test_protocol_error;
    test_back_to_back;
    test_drop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
